// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, immediate
// extension modes, the opcodes that select them, and the default boot address.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [1:0] EOP_SIGN  = 2'b00;
    localparam logic [1:0] EOP_ZERO  = 2'b01;
    localparam logic [1:0] EOP_UPPER = 2'b10;
    localparam logic [1:0] EOP_SHL2  = 2'b11;

    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/eop_dec.sv
// Immediate extension mode decode from the primary opcode.
// Latency: combinational. Backpressure: none, pure function of opcode.
// Unlisted opcodes fall back to plain sign extension.
module eop_dec
    import ifu_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [1:0] eop
);

    always_comb begin
        eop = EOP_SIGN;
        case (opcode)
            OP_LUI:                   eop = EOP_UPPER;
            OP_ANDI, OP_ORI, OP_XORI: eop = EOP_ZERO;
            OP_BEQ, OP_BNE:           eop = EOP_SHL2;
            default:                  eop = EOP_SIGN;
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: issues word fetches, holds the returned word for decode.
// Latency: one cycle from accepted imem response to instr_valid.
// Backpressure: stall keeps the held word in HOLD; redirect overrides stall.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] npc,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_valid,
    output logic [15:0]       imm,
    output logic [1:0]        EOp
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] fetch_addr, fetch_addr_nxt;
    logic [ADDR_W-1:0] npc_aligned;
    logic              valid_nxt;
    logic              load_ir;

    // Low address bits of a redirect target are dropped, never trusted.
    assign npc_aligned = npc & ~ADDR_W'(3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fetch_addr  <= RESET_PC;
            instr       <= '0;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            fetch_addr  <= fetch_addr_nxt;
            instr_valid <= valid_nxt;
            if (load_ir) begin
                instr <= imem_rdata;
                pc    <= fetch_addr;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        fetch_addr_nxt = fetch_addr;
        valid_nxt      = instr_valid;
        load_ir        = 1'b0;
        case (state)
            IDLE: begin
                state_nxt      = FETCH;
                fetch_addr_nxt = RESET_PC;
            end
            FETCH: begin
                // A response landing in the same cycle as a redirect is stale.
                if (redirect) begin
                    fetch_addr_nxt = npc_aligned;
                end else if (imem_rdy) begin
                    load_ir   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    fetch_addr_nxt = npc_aligned;
                    valid_nxt      = 1'b0;
                    state_nxt      = FETCH;
                end else if (!stall) begin
                    fetch_addr_nxt = pc + ADDR_W'(4);
                    valid_nxt      = 1'b0;
                    state_nxt      = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = fetch_addr;
    assign imm       = instr[15:0];

    eop_dec u_eop_dec (
        .opcode (instr[31:26]),
        .eop    (EOp)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: inputs change and outputs are checked on the
// falling edge, expected values are written out by hand per step.
module tb_ifu_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] npc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic [15:0] imm;
    logic [1:0]  EOp;

    int errors = 0;
    int checks = 0;

    ifu_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .npc         (npc),
        .instr       (instr),
        .pc          (pc),
        .instr_valid (instr_valid),
        .imm         (imm),
        .EOp         (EOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        imem_rdy   = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        redirect   = 1'b0;
        npc        = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req",   {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc",    pc, 32'h3000);
        chk("rst_addr",  imem_addr, 32'h3000);

        // Release; first edge is IDLE, request rises on the second
        reset    = 1'b0;
        imem_rdy = 1'b1;
        imem_rdata = 32'h3C01_1234;
        chk("idle_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("f0_req",  {31'b0, imem_req}, 32'd1);
        chk("f0_addr", imem_addr, 32'h3000);
        chk("f0_valid", {31'b0, instr_valid}, 32'd0);

        step();
        chk("lui_valid", {31'b0, instr_valid}, 32'd1);
        chk("lui_instr", instr, 32'h3C01_1234);
        chk("lui_pc",    pc, 32'h3000);
        chk("lui_imm",   {16'b0, imm}, 32'h1234);
        chk("lui_eop",   {30'b0, EOp}, 32'd2);
        chk("hold_req",  {31'b0, imem_req}, 32'd0);

        imem_rdata = 32'h3421_FFFF;
        step();
        chk("f1_addr",  imem_addr, 32'h3004);
        chk("f1_valid", {31'b0, instr_valid}, 32'd0);
        chk("f1_keep",  instr, 32'h3C01_1234);
        step();
        chk("ori_eop", {30'b0, EOp}, 32'd1);
        chk("ori_pc",  pc, 32'h3004);

        imem_rdata = 32'h1022_FFFE;
        step();
        chk("f2_addr", imem_addr, 32'h3008);
        step();
        chk("beq_eop", {30'b0, EOp}, 32'd3);
        chk("beq_imm", {16'b0, imm}, 32'hFFFE);

        // Five stalled cycles in HOLD
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stl_instr", instr, 32'h1022_FFFE);
            chk("stl_pc",    pc, 32'h3008);
            chk("stl_eop",   {30'b0, EOp}, 32'd3);
            chk("stl_req",   {31'b0, imem_req}, 32'd0);
            chk("stl_valid", {31'b0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        imem_rdata = 32'h2021_8000;
        step();
        chk("post_stl_addr", imem_addr, 32'h300C);
        chk("post_stl_req",  {31'b0, imem_req}, 32'd1);
        step();
        chk("addi_eop", {30'b0, EOp}, 32'd0);
        chk("addi_imm", {16'b0, imm}, 32'h8000);
        chk("addi_pc",  pc, 32'h300C);

        // Redirect overrides stall in HOLD
        stall    = 1'b1;
        redirect = 1'b1;
        npc      = 32'h0000_4003;
        step();
        chk("rdh_valid", {31'b0, instr_valid}, 32'd0);
        chk("rdh_req",   {31'b0, imem_req}, 32'd1);
        chk("rdh_addr",  imem_addr, 32'h4000);

        // Response coincident with redirect in FETCH is dropped
        stall      = 1'b0;
        npc        = 32'h0000_5001;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("rdf_valid", {31'b0, instr_valid}, 32'd0);
        chk("rdf_addr",  imem_addr, 32'h5000);
        chk("rdf_instr", instr, 32'h2021_8000);
        redirect   = 1'b0;
        imem_rdata = 32'h3C01_ABCD;
        step();
        chk("rdf_pc",    pc, 32'h5000);
        chk("rdf_new",   instr, 32'h3C01_ABCD);

        // Sequential fetch wraps past the top of the address space
        redirect = 1'b1;
        npc      = 32'hFFFF_FFFF;
        step();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        redirect   = 1'b0;
        imem_rdata = 32'h0000_0000;
        step();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        imem_rdy = 1'b0;
        step();
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        step();
        chk("wait_req", {31'b0, imem_req}, 32'd1);

        // Reset while FETCH waits, takes effect without a clock edge
        reset = 1'b1;
        #1;
        chk("arst_req",   {31'b0, imem_req}, 32'd0);
        chk("arst_valid", {31'b0, instr_valid}, 32'd0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_pc",    pc, 32'h3000);
        chk("arst_addr",  imem_addr, 32'h3000);
        @(negedge clk);
        reset    = 1'b0;
        imem_rdy = 1'b1;
        redirect = 1'b1;
        npc      = 32'h0000_7000;
        chk("re_idle_req", {31'b0, imem_req}, 32'd0);
        step();
        redirect = 1'b0;
        chk("re_req",  {31'b0, imem_req}, 32'd1);
        chk("re_addr", imem_addr, 32'h3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
